gpu_net_tx_arbiter: RTL

Round-robin arbiter that shares one GPU's 16-bit network-interface transmit port between up to N_REQ on-chip requesters (AXI-side bridge, test-traffic generator, DMA, ...). It sits between the requesters and the `net_data_out`/`net_valid_out`/`net_ready_in` port of the GPU. It captures one flit at a time, holds it stable until the network accepts it, and short-circuits flits addressed to its own GPU_ID onto a local-delivery port. Stall timeout detection and transfer counters are provided for debug.

---
 rtl/gpu_net_pkg.sv | 23 ++
 rtl/gpu_net_tx_arbiter_rr_pick.sv | 31 +++
 rtl/gpu_net_tx_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/gpu_net_pkg.sv
// Shared flit format and arbiter state definitions for the GPU network interface.
package gpu_net_pkg;

    localparam int unsigned DEST_W    = 6;
    localparam int unsigned PAYLOAD_W = 10;
    localparam int unsigned FLIT_W    = 16;
    localparam int unsigned IDX_W     = 3;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_SEND  = 2'd1,
        ST_LOCAL = 2'd2
    } arb_state_t;

    function automatic logic [DEST_W-1:0] flit_dest(input logic [FLIT_W-1:0] flit);
        return flit[FLIT_W-1 -: DEST_W];
    endfunction

    function automatic logic [PAYLOAD_W-1:0] flit_payload(input logic [FLIT_W-1:0] flit);
        return flit[PAYLOAD_W-1:0];
    endfunction

endpackage

// File: rtl/gpu_net_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping at N.
module rr_pick
    import gpu_net_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    int unsigned k;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int unsigned off = 0; off < N; off++) begin
            k = (32'(ptr) + off) % N;
            if (!found && req[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                idx      = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/gpu_net_tx_arbiter.sv
// Round-robin transmit arbiter for the GPU network port, with local loopback,
// stall timeout and debug transfer counters.
module gpu_net_tx_arbiter
    import gpu_net_pkg::*;
#(
    parameter int unsigned GPU_ID  = 5,
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [FLIT_W*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic [FLIT_W-1:0]         net_data_out,
    output logic                      net_valid_out,
    input  logic                      net_ready_in,
    output logic [PAYLOAD_W-1:0]      local_data_out,
    output logic                      local_valid_out,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      busy,
    output logic                      err_timeout,
    output logic [15:0]               sent_count,
    output logic [15:0]               drop_count
);

    arb_state_t         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [15:0]        wait_cnt;
    logic [N_REQ-1:0]   pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic [FLIT_W-1:0]  pick_flit;
    logic [IDX_W:0]     ptr_inc;

    rr_pick #(.N(N_REQ)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        pick_flit = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (32'(pick_idx) == i) begin
                pick_flit = req_data[i*FLIT_W +: FLIT_W];
            end
        end
    end

    assign ptr_inc   = {1'b0, pick_idx} + (IDX_W+1)'(1);
    assign req_ready = (state == ST_ARB) ? pick_grant : '0;

    // net_data_out and local_data_out are separate registers so the network
    // word keeps its last value across loopback grants.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state           <= ST_ARB;
            rr_ptr          <= '0;
            wait_cnt        <= '0;
            net_data_out    <= '0;
            net_valid_out   <= 1'b0;
            local_data_out  <= '0;
            local_valid_out <= 1'b0;
            grant_id        <= '0;
            busy            <= 1'b0;
            err_timeout     <= 1'b0;
            sent_count      <= '0;
            drop_count      <= '0;
        end else begin
            local_valid_out <= 1'b0;
            case (state)
                ST_ARB: begin
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        rr_ptr   <= (ptr_inc == (IDX_W+1)'(N_REQ)) ? '0 : ptr_inc[IDX_W-1:0];
                        wait_cnt <= '0;
                        busy     <= 1'b1;
                        if (flit_dest(pick_flit) == DEST_W'(GPU_ID)) begin
                            state           <= ST_LOCAL;
                            local_valid_out <= 1'b1;
                            local_data_out  <= flit_payload(pick_flit);
                        end else begin
                            state         <= ST_SEND;
                            net_valid_out <= 1'b1;
                            net_data_out  <= pick_flit;
                        end
                    end
                end
                ST_SEND: begin
                    if (net_ready_in) begin
                        sent_count    <= sent_count + 16'd1;
                        net_valid_out <= 1'b0;
                        busy          <= 1'b0;
                        state         <= ST_ARB;
                    end else if (wait_cnt == 16'(TIMEOUT)) begin
                        drop_count    <= drop_count + 16'd1;
                        err_timeout   <= 1'b1;
                        net_valid_out <= 1'b0;
                        busy          <= 1'b0;
                        state         <= ST_ARB;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                ST_LOCAL: begin
                    busy  <= 1'b0;
                    state <= ST_ARB;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_ARB;
                end
            endcase
        end
    end

endmodule
